// File: rtl/c499_lock_pkg.sv
// c499_lock_pkg: shared widths, FSM states and c499 N-number to bit-position helpers
package c499_lock_pkg;
  localparam int KEY_W = 10;
  localparam int IN_W = 41;
  localparam int OUT_W = 32;
  typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_SETTLE, ST_RESP} state_e;
  function automatic int in_pos(input int n);
    return (n <= 129) ? (n - 1) / 4 : n - 97;
  endfunction
  function automatic int out_pos(input int n);
    return n - 724;
  endfunction
  function automatic logic in_bit(input logic [IN_W-1:0] v, input int n);
    return v[in_pos(n)];
  endfunction
  function automatic logic out_bit(input logic [OUT_W-1:0] v, input int n);
    return v[out_pos(n)];
  endfunction
endpackage

// File: rtl/c499_key_shift.sv
// c499_key_shift: serial key shadow register with saturating bit count
module c499_key_shift import c499_lock_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             sen_i,
  input  logic             sin_i,
  input  logic             clr_i,
  output logic [KEY_W-1:0] shadow_o,
  output logic             full_o
);
  localparam int CW = $clog2(KEY_W + 1);
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign shadow_o = shadow_q;
  assign full_o = cnt_q == CW'(KEY_W);
  // shift LSB-first; a clear still counts a bit shifted in the same cycle
  always_comb begin
    shadow_d = sen_i ? {sin_i, shadow_q[KEY_W-1:1]} : shadow_q;
    cnt_d = clr_i ? CW'(sen_i) : (sen_i && !full_o) ? cnt_q + CW'(1) : cnt_q;
  end
  // shadow and count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/c499_lock_seq_ctrl.sv
// c499_lock_seq_ctrl: key-commit and vector sequencer in front of the combinational c499 core
module c499_lock_seq_ctrl import c499_lock_pkg::*; #(
  parameter int               SETTLE  = 2,
  parameter logic [KEY_W-1:0] KEY_RST = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_sin,
  input  logic             key_sen,
  input  logic             key_commit,
  output logic             key_full,
  output logic             key_err,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IN_W-1:0]  core_in,
  output logic [KEY_W-1:0] core_key,
  input  logic [OUT_W-1:0] core_out,
  output logic             busy
);
  localparam int CW = $clog2(SETTLE + 1);
  state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0] core_in_q, core_in_d;
  logic [KEY_W-1:0] core_key_q, core_key_d, shadow;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic out_valid_q, out_valid_d, pend_q, pend_d, key_err_q, key_err_d, clr;
  c499_key_shift u_shift (
    .clk(clk), .rst(rst), .sen_i(key_sen), .sin_i(key_sin), .clr_i(clr),
    .shadow_o(shadow), .full_o(key_full)
  );
  assign in_ready = state_q == ST_IDLE && !pend_q && !rst;
  assign busy = state_q != ST_IDLE;
  assign core_in = core_in_q;
  assign core_key = core_key_q;
  assign out_data = out_data_q;
  assign out_valid = out_valid_q;
  assign key_err = key_err_q;
  // pending commits take priority in IDLE so the key only moves between vectors
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    core_in_d = core_in_q;
    core_key_d = core_key_q;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q;
    pend_d = pend_q | (key_commit & key_full);
    key_err_d = key_commit & ~key_full;
    clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) state_d = ST_COMMIT;
        else if (in_valid) begin
          core_in_d = in_data;
          cnt_d = CW'(SETTLE - 1);
          state_d = ST_SETTLE;
        end
      end
      ST_COMMIT: begin
        core_key_d = shadow;
        clr = 1'b1;
        pend_d = 1'b0;
        state_d = ST_IDLE;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          out_data_d = core_out;
          out_valid_d = 1'b1;
          state_d = ST_RESP;
        end else cnt_d = cnt_q - CW'(1);
      end
      ST_RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      core_in_q <= '0;
      core_key_q <= KEY_RST;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      pend_q <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      core_in_q <= core_in_d;
      core_key_q <= core_key_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      pend_q <= pend_d;
      key_err_q <= key_err_d;
    end
  end
endmodule
